// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selections and default oversampling.
package uart_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rxState_t;

  localparam logic [1:0] NONE0 = 2'b00;
  localparam logic [1:0] ODD   = 2'b01;
  localparam logic [1:0] EVEN  = 2'b10;
  localparam logic [1:0] NONE3 = 2'b11;

  function automatic logic parityEnabled(input logic [1:0] parityType);
    return (parityType == ODD) || (parityType == EVEN);
  endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module rx_synchronizer (
  input  logic Clock,
  input  logic Reset,
  input  logic RxIn,
  output logic RxS
);

  logic meta;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta <= 1'b1;
      RxS  <= 1'b1;
    end else begin
      meta <= RxIn;
      RxS  <= meta;
    end
  end

endmodule

// File: rtl/frame_receiver.sv
// Oversampling UART frame receiver: 7/8 data bits, optional odd/even parity, 1/2 stop bits.
module frame_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BaudTick,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       ParityError,
  output logic       FrameError,
  output logic       Busy
);

  localparam int unsigned TICK_W    = $clog2(OVERSAMPLE);
  localparam int unsigned HALF_LAST = OVERSAMPLE / 2 - 1;
  localparam int unsigned MID_LAST  = OVERSAMPLE - 1;

  rxState_t          state, nextState;
  logic [TICK_W-1:0] tickCnt, tickNext;
  logic [2:0]        bitCnt, bitNext;
  logic [7:0]        shadow, shadowNext;
  logic              parAcc, parAccNext;
  logic              parErr, parErrNext;
  logic              frmErr, frmErrNext;
  logic [1:0]        cfgParity;
  logic              cfgStop;
  logic              cfgLen;
  logic              latchCfg;
  logic              frameDone;
  logic              rxS;
  logic              midBit;
  logic [2:0]        lastData;

  rx_synchronizer uSync (
    .Clock (Clock),
    .Reset (Reset),
    .RxIn  (RxIn),
    .RxS   (rxS)
  );

  assign midBit   = (tickCnt == TICK_W'(MID_LAST));
  assign lastData = cfgLen ? 3'd7 : 3'd6;

  // Next-state and shadow datapath; everything except DONE advances only on BaudTick.
  always_comb begin
    nextState  = state;
    tickNext   = tickCnt;
    bitNext    = bitCnt;
    shadowNext = shadow;
    parAccNext = parAcc;
    parErrNext = parErr;
    frmErrNext = frmErr;
    latchCfg   = 1'b0;
    frameDone  = 1'b0;

    unique case (state)
      IDLE: begin
        if (BaudTick && !rxS) begin
          nextState = START;
          tickNext  = '0;
          latchCfg  = 1'b1;
        end
      end

      START: begin
        if (BaudTick) begin
          if (tickCnt == TICK_W'(HALF_LAST)) begin
            tickNext = '0;
            bitNext  = '0;
            if (!rxS) begin
              nextState  = DATA;
              shadowNext = '0;
              parAccNext = 1'b0;
              parErrNext = 1'b0;
              frmErrNext = 1'b0;
            end else begin
              nextState = IDLE;
            end
          end else begin
            tickNext = tickCnt + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (BaudTick) begin
          if (midBit) begin
            tickNext           = '0;
            shadowNext[bitCnt] = rxS;
            parAccNext         = parAcc ^ rxS;
            if (bitCnt == lastData) begin
              bitNext   = '0;
              nextState = parityEnabled(cfgParity) ? PARITY : STOP;
            end else begin
              bitNext = bitCnt + 3'd1;
            end
          end else begin
            tickNext = tickCnt + TICK_W'(1);
          end
        end
      end

      PARITY: begin
        if (BaudTick) begin
          if (midBit) begin
            tickNext   = '0;
            bitNext    = '0;
            parErrNext = (cfgParity == ODD) ? ~(parAcc ^ rxS) : (parAcc ^ rxS);
            nextState  = STOP;
          end else begin
            tickNext = tickCnt + TICK_W'(1);
          end
        end
      end

      STOP: begin
        if (BaudTick) begin
          if (midBit) begin
            tickNext = '0;
            if (!rxS) frmErrNext = 1'b1;
            if (bitCnt == {2'b00, cfgStop}) begin
              nextState = DONE;
              frameDone = 1'b1;
            end else begin
              bitNext = bitCnt + 3'd1;
            end
          end else begin
            tickNext = tickCnt + TICK_W'(1);
          end
        end
      end

      DONE: begin
        nextState = IDLE;
        tickNext  = '0;
        bitNext   = '0;
      end

      default: begin
        nextState = IDLE;
        tickNext  = '0;
        bitNext   = '0;
      end
    endcase
  end

  // State, counters, latched frame configuration and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      tickCnt     <= '0;
      bitCnt      <= '0;
      shadow      <= '0;
      parAcc      <= 1'b0;
      parErr      <= 1'b0;
      frmErr      <= 1'b0;
      cfgParity   <= NONE0;
      cfgStop     <= 1'b0;
      cfgLen      <= 1'b0;
      DataOut     <= '0;
      DataValid   <= 1'b0;
      ParityError <= 1'b0;
      FrameError  <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state     <= nextState;
      tickCnt   <= tickNext;
      bitCnt    <= bitNext;
      shadow    <= shadowNext;
      parAcc    <= parAccNext;
      parErr    <= parErrNext;
      frmErr    <= frmErrNext;
      DataValid <= frameDone;
      Busy      <= (nextState != IDLE);
      if (latchCfg) begin
        cfgParity <= ParityType;
        cfgStop   <= StopBits;
        cfgLen    <= DataLength;
      end
      if (frameDone) begin
        DataOut     <= shadowNext;
        ParityError <= parErrNext;
        FrameError  <= frmErrNext;
      end
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Scoreboard bench for frame_receiver: serial frames are driven and expected words queued.
module tb_frame_receiver;
  import uart_pkg::*;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLKS = OS * TICK_DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       BaudTick;
  logic       RxIn;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       DataLength;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       ParityError;
  logic       FrameError;
  logic       Busy;

  logic [1:0] divCnt = 2'd0;
  exp_t       expQ[$];
  int         testsRun    = 0;
  int         testsFailed = 0;
  int         validSeen   = 0;
  logic       prevValid   = 1'b0;

  frame_receiver #(.OVERSAMPLE(OS)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BaudTick    (BaudTick),
    .RxIn        (RxIn),
    .ParityType  (ParityType),
    .StopBits    (StopBits),
    .DataLength  (DataLength),
    .DataOut     (DataOut),
    .DataValid   (DataValid),
    .ParityError (ParityError),
    .FrameError  (FrameError),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  always_ff @(posedge Clock) divCnt <= divCnt + 2'd1;
  assign BaudTick = (divCnt == 2'd0);

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Advance n clocks, sampling at the falling edge and scoring every DataValid pulse.
  task automatic step(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge Clock);
      if (DataValid === 1'b1) begin
        validSeen++;
        testsRun++;
        if (prevValid) begin
          testsFailed++;
          $display("FAIL valid_width: DataValid high on consecutive clocks, expected one-clock pulse");
        end
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("FAIL unexpected_valid: got DataOut=%h, expected no frame", DataOut);
        end else begin
          e = expQ.pop_front();
          testsRun++;
          if (DataOut !== e.data) begin
            testsFailed++;
            $display("FAIL data: got %h, expected %h", DataOut, e.data);
          end
          testsRun++;
          if (ParityError !== e.pe) begin
            testsFailed++;
            $display("FAIL parity_error: got %b, expected %b (data %h)", ParityError, e.pe, e.data);
          end
          testsRun++;
          if (FrameError !== e.fe) begin
            testsFailed++;
            $display("FAIL frame_error: got %b, expected %b (data %h)", FrameError, e.fe, e.data);
          end
        end
      end
      prevValid = (DataValid === 1'b1);
    end
  endtask

  task automatic sendBit(input logic b);
    RxIn = b;
    step(BIT_CLKS);
  endtask

  // Drive one frame on the line and queue its expected result; scramble toggles config inputs mid-frame.
  task automatic sendFrame(input logic [7:0] d, input logic len8, input logic [1:0] ptype,
                           input logic flipPar, input logic stop2, input logic stopVal,
                           input logic scramble);
    exp_t e;
    int   nb;
    logic par;
    nb  = len8 ? 8 : 7;
    par = 1'b0;
    for (int i = 0; i < nb; i++) par = par ^ d[i];
    e.data = len8 ? d : {1'b0, d[6:0]};
    e.pe   = (ptype == ODD || ptype == EVEN) ? flipPar : 1'b0;
    e.fe   = ~stopVal;
    expQ.push_back(e);
    ParityType = ptype;
    StopBits   = stop2;
    DataLength = len8;
    sendBit(1'b0);
    if (scramble) begin
      ParityType = ~ptype;
      StopBits   = ~stop2;
      DataLength = ~len8;
    end
    for (int i = 0; i < nb; i++) sendBit(d[i]);
    if (ptype == ODD) sendBit(~par ^ flipPar);
    else if (ptype == EVEN) sendBit(par ^ flipPar);
    sendBit(stopVal);
    if (stop2) sendBit(stopVal);
    RxIn = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("FAIL drain: %0d frames still pending after %0d clocks, expected 0", expQ.size(), budget);
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    Reset      = 1'b1;
    RxIn       = 1'b1;
    ParityType = NONE0;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    step(4);
    testsRun++;
    if (DataOut !== 8'h00) begin testsFailed++; $display("FAIL reset_data: got %h, expected 00", DataOut); end
    testsRun++;
    if (DataValid !== 1'b0) begin testsFailed++; $display("FAIL reset_valid: got %b, expected 0", DataValid); end
    testsRun++;
    if (ParityError !== 1'b0) begin testsFailed++; $display("FAIL reset_pe: got %b, expected 0", ParityError); end
    testsRun++;
    if (FrameError !== 1'b0) begin testsFailed++; $display("FAIL reset_fe: got %b, expected 0", FrameError); end
    testsRun++;
    if (Busy !== 1'b0) begin testsFailed++; $display("FAIL reset_busy: got %b, expected 0", Busy); end
    Reset = 1'b0;
    step(2 * BIT_CLKS);
  endtask

  task automatic test_8n1();
    int v0;
    v0 = validSeen;
    sendFrame(8'hA5, 1'b1, NONE0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain(4 * BIT_CLKS);
    step(BIT_CLKS);
    testsRun++;
    if (validSeen - v0 != 1) begin testsFailed++; $display("FAIL 8n1_pulses: got %0d, expected 1", validSeen - v0); end
    testsRun++;
    if (Busy !== 1'b0) begin testsFailed++; $display("FAIL 8n1_busy_after: got %b, expected 0", Busy); end
  endtask

  task automatic test_7e2_parity();
    sendFrame(8'h35, 1'b0, EVEN, 1'b1, 1'b1, 1'b1, 1'b0);
    waitDrain(4 * BIT_CLKS);
    step(BIT_CLKS);
    testsRun++;
    if (ParityError !== 1'b1) begin testsFailed++; $display("FAIL 7e2_pe_held: got %b, expected 1", ParityError); end
  endtask

  task automatic test_8o1_frame_error();
    int v0;
    v0 = validSeen;
    sendFrame(8'h3C, 1'b1, ODD, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain(4 * BIT_CLKS);
    step(2 * BIT_CLKS);
    testsRun++;
    if (validSeen - v0 != 1) begin testsFailed++; $display("FAIL 8o1_pulses: got %0d, expected 1", validSeen - v0); end
    testsRun++;
    if (FrameError !== 1'b1) begin testsFailed++; $display("FAIL 8o1_fe_held: got %b, expected 1", FrameError); end
    testsRun++;
    if (Busy !== 1'b0) begin testsFailed++; $display("FAIL 8o1_busy_after: got %b, expected 0", Busy); end
  endtask

  task automatic test_glitch();
    int v0;
    int busyClks;
    v0 = validSeen;
    busyClks = 0;
    ParityType = NONE0;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    RxIn = 1'b0;
    for (int i = 0; i < int'(4 * TICK_DIV); i++) begin
      step(1);
      if (Busy === 1'b1) busyClks++;
    end
    RxIn = 1'b1;
    for (int i = 0; i < int'(2 * BIT_CLKS); i++) begin
      step(1);
      if (Busy === 1'b1) busyClks++;
    end
    testsRun++;
    if (validSeen != v0) begin testsFailed++; $display("FAIL glitch_valid: got %0d pulses, expected 0", validSeen - v0); end
    testsRun++;
    if (busyClks == 0 || busyClks > int'(8 * TICK_DIV)) begin
      testsFailed++;
      $display("FAIL glitch_busy: got %0d busy clocks, expected 1..%0d", busyClks, 8 * TICK_DIV);
    end
    testsRun++;
    if (Busy !== 1'b0) begin testsFailed++; $display("FAIL glitch_idle: got busy %b, expected 0", Busy); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = validSeen;
    sendFrame(8'h55, 1'b1, NONE3, 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(8'hFF, 1'b1, NONE0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDrain(4 * BIT_CLKS);
    step(BIT_CLKS);
    testsRun++;
    if (validSeen - v0 != 2) begin testsFailed++; $display("FAIL b2b_pulses: got %0d, expected 2", validSeen - v0); end
  endtask

  task automatic test_reset_mid_frame();
    int   v0;
    logic [7:0] d;
    v0 = validSeen;
    d  = 8'h81;
    ParityType = NONE0;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(d[i]);
    Reset = 1'b1;
    step(2);
    testsRun++;
    if (Busy !== 1'b0) begin testsFailed++; $display("FAIL midrst_busy: got %b, expected 0", Busy); end
    testsRun++;
    if (DataOut !== 8'h00) begin testsFailed++; $display("FAIL midrst_data: got %h, expected 00", DataOut); end
    Reset = 1'b0;
    RxIn  = 1'b1;
    step(2 * BIT_CLKS);
    sendFrame(8'h42, 1'b1, NONE0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDrain(4 * BIT_CLKS);
    step(BIT_CLKS);
    testsRun++;
    if (validSeen - v0 != 1) begin testsFailed++; $display("FAIL midrst_pulses: got %0d, expected 1", validSeen - v0); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2_parity();
    test_8o1_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
